vend_session_ctrl: RTL and testbench

Session controller that sits in front of the vending datapath and sequences one customer transaction. It accumulates coins over many cycles, validates the product selection against the accumulated credit, and handshakes with the dispense mechanism. It then issues a one-cycle product pulse and a one-cycle change/refund report. It also handles cancel and inactivity timeout so that the credit is always either spent or returned.

---
 rtl/vend_pkg.sv | 43 ++++
 rtl/vend_timeout_ctr.sv | 30 +++
 rtl/vend_session_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vend_session_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: product codes, prices, legal coins, FSM states
// and the price lookup used by the session controller.
package vend_pkg;

  localparam int unsigned AMT_W = 5;
  localparam int unsigned SUM_W = 6;
  localparam int unsigned PROD_W = 2;

  localparam logic [PROD_W-1:0] PROD_NONE      = 2'b00;
  localparam logic [PROD_W-1:0] PROD_NEWSPAPER = 2'b01;
  localparam logic [PROD_W-1:0] PROD_CHOCOLATE = 2'b10;
  localparam logic [PROD_W-1:0] PROD_COKE      = 2'b11;

  localparam logic [AMT_W-1:0] PRICE_NEWSPAPER = 5'd5;
  localparam logic [AMT_W-1:0] PRICE_CHOCOLATE = 5'd10;
  localparam logic [AMT_W-1:0] PRICE_COKE      = 5'd15;

  localparam logic [AMT_W-1:0] COIN_5  = 5'd5;
  localparam logic [AMT_W-1:0] COIN_10 = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  function automatic logic [AMT_W-1:0] price_of(input logic [PROD_W-1:0] code);
    logic [AMT_W-1:0] p;
    case (code)
      PROD_NEWSPAPER: p = PRICE_NEWSPAPER;
      PROD_CHOCOLATE: p = PRICE_CHOCOLATE;
      PROD_COKE:      p = PRICE_COKE;
      default:        p = '0;
    endcase
    return p;
  endfunction

  function automatic logic coin_legal(input logic [AMT_W-1:0] value);
    return (value == COIN_5) || (value == COIN_10);
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Inactivity counter: clear wins over enable; saturates at TERMINAL-1 and
// flags that value combinationally.
module vend_timeout_ctr #(
  parameter int unsigned TERMINAL = 255,
  parameter int unsigned CNT_W    = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [CNT_W-1:0] r_count;
  logic             w_tc;

  assign w_tc   = (r_count == CNT_W'(TERMINAL - 1));
  assign o_tc_c = w_tc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vend_session_ctrl.sv
// One-customer vending session: coin accumulation, selection check,
// dispense handshake, change/refund report, cancel and inactivity refund.
module vend_session_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_CREDIT     = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_valid,
  input  logic [AMT_W-1:0]  coin_value,
  input  logic              sel_valid,
  input  logic [PROD_W-1:0] select_product,
  input  logic              cancel,
  input  logic              dispense_ready,
  output logic              newspaper,
  output logic              chocolate,
  output logic              coke,
  output logic [AMT_W-1:0]  balance,
  output logic              balance_valid,
  output logic [AMT_W-1:0]  credit,
  output logic              coin_reject,
  output logic              sel_short,
  output logic              busy
);

  localparam int unsigned TMO_W = 16;

  state_t            r_state, w_state_nx;
  logic [AMT_W-1:0]  r_credit, w_credit_nx;
  logic [AMT_W-1:0]  r_price, w_price_nx;
  logic [PROD_W-1:0] r_prod, w_prod_nx;
  logic [AMT_W-1:0]  r_change, w_change_nx;
  logic [AMT_W-1:0]  r_balance, w_balance_nx;
  logic              r_newspaper, w_newspaper_nx;
  logic              r_chocolate, w_chocolate_nx;
  logic              r_coke, w_coke_nx;
  logic              r_bal_valid, w_bal_valid_nx;
  logic              r_coin_reject, w_coin_reject_nx;
  logic              r_sel_short, w_sel_short_nx;
  logic              r_busy, w_busy_nx;

  logic              w_coin_acc;
  logic              w_coin_ok;
  logic [SUM_W-1:0]  w_sum;
  logic [AMT_W-1:0]  w_sel_price;
  logic              w_tmo_tc;
  logic              w_tmo_clr;
  logic              w_tmo_en;

  assign w_coin_ok   = coin_legal(coin_value);
  assign w_sum       = SUM_W'(r_credit) + SUM_W'(coin_value);
  assign w_sel_price = price_of(select_product);
  assign w_tmo_clr   = (r_state != ST_CREDIT) || w_coin_acc;
  assign w_tmo_en    = (r_state == ST_CREDIT);

  vend_timeout_ctr #(
    .TERMINAL (TIMEOUT_CYCLES),
    .CNT_W    (TMO_W)
  ) u_timeout (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_tmo_clr),
    .i_en   (w_tmo_en),
    .o_tc_c (w_tmo_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_credit      <= '0;
      r_price       <= '0;
      r_prod        <= PROD_NONE;
      r_change      <= '0;
      r_balance     <= '0;
      r_newspaper   <= 1'b0;
      r_chocolate   <= 1'b0;
      r_coke        <= 1'b0;
      r_bal_valid   <= 1'b0;
      r_coin_reject <= 1'b0;
      r_sel_short   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_credit      <= w_credit_nx;
      r_price       <= w_price_nx;
      r_prod        <= w_prod_nx;
      r_change      <= w_change_nx;
      r_balance     <= w_balance_nx;
      r_newspaper   <= w_newspaper_nx;
      r_chocolate   <= w_chocolate_nx;
      r_coke        <= w_coke_nx;
      r_bal_valid   <= w_bal_valid_nx;
      r_coin_reject <= w_coin_reject_nx;
      r_sel_short   <= w_sel_short_nx;
      r_busy        <= w_busy_nx;
    end
  end

  // Priority inside CREDIT: cancel > selection > coin > inactivity timeout.
  always_comb begin
    w_state_nx       = r_state;
    w_credit_nx      = r_credit;
    w_price_nx       = r_price;
    w_prod_nx        = r_prod;
    w_change_nx      = r_change;
    w_balance_nx     = r_balance;
    w_newspaper_nx   = 1'b0;
    w_chocolate_nx   = 1'b0;
    w_coke_nx        = 1'b0;
    w_bal_valid_nx   = 1'b0;
    w_coin_reject_nx = 1'b0;
    w_sel_short_nx   = 1'b0;
    w_coin_acc       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (coin_valid) begin
          if (w_coin_ok) begin
            w_credit_nx = coin_value;
            w_coin_acc  = 1'b1;
            w_state_nx  = ST_CREDIT;
          end else begin
            w_coin_reject_nx = 1'b1;
          end
        end
      end

      ST_CREDIT: begin
        if (cancel) begin
          w_coin_reject_nx = coin_valid;
          w_change_nx      = r_credit;
          w_state_nx       = ST_CHANGE;
        end else if (sel_valid && (select_product != PROD_NONE)) begin
          w_coin_reject_nx = coin_valid;
          if (w_sel_price <= r_credit) begin
            w_prod_nx  = select_product;
            w_price_nx = w_sel_price;
            w_state_nx = ST_DISPENSE;
          end else begin
            w_sel_short_nx = 1'b1;
            if (w_tmo_tc) begin
              w_change_nx = r_credit;
              w_state_nx  = ST_CHANGE;
            end
          end
        end else if (coin_valid && w_coin_ok && (w_sum <= SUM_W'(MAX_CREDIT))) begin
          w_credit_nx = AMT_W'(w_sum);
          w_coin_acc  = 1'b1;
        end else begin
          w_coin_reject_nx = coin_valid;
          if (w_tmo_tc) begin
            w_change_nx = r_credit;
            w_state_nx  = ST_CHANGE;
          end
        end
      end

      ST_DISPENSE: begin
        w_coin_reject_nx = coin_valid;
        if (dispense_ready) begin
          w_newspaper_nx = (r_prod == PROD_NEWSPAPER);
          w_chocolate_nx = (r_prod == PROD_CHOCOLATE);
          w_coke_nx      = (r_prod == PROD_COKE);
          w_change_nx    = r_credit - r_price;
          w_state_nx     = ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        w_coin_reject_nx = coin_valid;
        w_bal_valid_nx   = 1'b1;
        w_balance_nx     = r_change;
        w_credit_nx      = '0;
        w_state_nx       = ST_IDLE;
      end

      default: begin
        w_credit_nx = '0;
        w_state_nx  = ST_IDLE;
      end
    endcase

    w_busy_nx = (w_state_nx == ST_DISPENSE) || (w_state_nx == ST_CHANGE);
  end

  assign newspaper     = r_newspaper;
  assign chocolate     = r_chocolate;
  assign coke          = r_coke;
  assign balance       = r_balance;
  assign balance_valid = r_bal_valid;
  assign credit        = r_credit;
  assign coin_reject   = r_coin_reject;
  assign sel_short     = r_sel_short;
  assign busy          = r_busy;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Directed bench for vend_session_ctrl; outputs are sampled 1 time unit after
// each rising edge against hand-computed values.
module tb_vend_session_ctrl;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [4:0] coin_value;
  logic       sel_valid;
  logic [1:0] select_product;
  logic       cancel;
  logic       dispense_ready;
  logic       newspaper;
  logic       chocolate;
  logic       coke;
  logic [4:0] balance;
  logic       balance_valid;
  logic [4:0] credit;
  logic       coin_reject;
  logic       sel_short;
  logic       busy;

  int n_pass;
  int n_total;

  vend_session_ctrl #(
    .TIMEOUT_CYCLES (8),
    .MAX_CREDIT     (31)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .sel_valid      (sel_valid),
    .select_product (select_product),
    .cancel         (cancel),
    .dispense_ready (dispense_ready),
    .newspaper      (newspaper),
    .chocolate      (chocolate),
    .coke           (coke),
    .balance        (balance),
    .balance_valid  (balance_valid),
    .credit         (credit),
    .coin_reject    (coin_reject),
    .sel_short      (sel_short),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic inp(input logic cv, input logic [4:0] val, input logic sv,
                     input logic [1:0] sp, input logic cn);
    coin_valid     = cv;
    coin_value     = val;
    sel_valid      = sv;
    select_product = sp;
    cancel         = cn;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    dispense_ready = 1'b0;
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);

    // reset state
    repeat (2) tick();
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bal_valid", 32'(balance_valid), 32'd0);
    chk("rst_balance", 32'(balance), 32'd0);
    chk("rst_coin_reject", 32'(coin_reject), 32'd0);
    rst = 1'b0;

    // IDLE ignores selection and cancel
    inp(1'b0, 5'd0, 1'b1, 2'b11, 1'b1);
    tick();
    chk("idle_ign_busy", 32'(busy), 32'd0);
    chk("idle_ign_short", 32'(sel_short), 32'd0);
    chk("idle_ign_bval", 32'(balance_valid), 32'd0);

    // 5+5+5, coke, ready high
    dispense_ready = 1'b1;
    inp(1'b1, 5'd5, 1'b0, 2'b00, 1'b0);
    tick(); chk("t1_credit5", 32'(credit), 32'd5);
    tick(); chk("t1_credit10", 32'(credit), 32'd10);
    tick(); chk("t1_credit15", 32'(credit), 32'd15);
    inp(1'b0, 5'd0, 1'b1, 2'b11, 1'b0);
    tick(); chk("t1_disp_busy", 32'(busy), 32'd1);
    chk("t1_disp_coke0", 32'(coke), 32'd0);
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    tick(); chk("t1_coke", 32'(coke), 32'd1);
    chk("t1_chg_busy", 32'(busy), 32'd1);
    tick(); chk("t1_coke_off", 32'(coke), 32'd0);
    chk("t1_bval", 32'(balance_valid), 32'd1);
    chk("t1_balance", 32'(balance), 32'd0);
    chk("t1_credit0", 32'(credit), 32'd0);
    tick(); chk("t1_bval_off", 32'(balance_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 10+10, chocolate, ready delayed 3 cycles, coin during DISPENSE rejected
    dispense_ready = 1'b0;
    inp(1'b1, 5'd10, 1'b0, 2'b00, 1'b0);
    tick(); chk("t2_credit10", 32'(credit), 32'd10);
    tick(); chk("t2_credit20", 32'(credit), 32'd20);
    inp(1'b0, 5'd0, 1'b1, 2'b10, 1'b0);
    tick(); chk("t2_disp_busy", 32'(busy), 32'd1);
    inp(1'b1, 5'd5, 1'b0, 2'b00, 1'b0);
    tick(); chk("t2_disp_rej", 32'(coin_reject), 32'd1);
    chk("t2_disp_credit", 32'(credit), 32'd20);
    chk("t2_wait1_choc", 32'(chocolate), 32'd0);
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    tick(); chk("t2_wait2_choc", 32'(chocolate), 32'd0);
    tick(); chk("t2_wait3_choc", 32'(chocolate), 32'd0);
    chk("t2_wait3_busy", 32'(busy), 32'd1);
    dispense_ready = 1'b1;
    tick(); chk("t2_choc", 32'(chocolate), 32'd1);
    dispense_ready = 1'b0;
    tick(); chk("t2_bval", 32'(balance_valid), 32'd1);
    chk("t2_balance", 32'(balance), 32'd10);
    chk("t2_credit0", 32'(credit), 32'd0);

    // 5, coke refused, then cancel
    inp(1'b1, 5'd5, 1'b0, 2'b00, 1'b0);
    tick(); chk("t3_credit5", 32'(credit), 32'd5);
    inp(1'b0, 5'd0, 1'b1, 2'b11, 1'b0);
    tick(); chk("t3_short", 32'(sel_short), 32'd1);
    chk("t3_short_credit", 32'(credit), 32'd5);
    chk("t3_short_busy", 32'(busy), 32'd0);
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b1);
    tick(); chk("t3_cancel_busy", 32'(busy), 32'd1);
    chk("t3_short_off", 32'(sel_short), 32'd0);
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    tick(); chk("t3_bval", 32'(balance_valid), 32'd1);
    chk("t3_balance", 32'(balance), 32'd5);
    chk("t3_credit0", 32'(credit), 32'd0);
    tick(); chk("t3_idle_busy", 32'(busy), 32'd0);

    // illegal coin, then ceiling overflow at 35
    inp(1'b1, 5'd7, 1'b0, 2'b00, 1'b0);
    tick(); chk("t4_illegal_rej", 32'(coin_reject), 32'd1);
    chk("t4_illegal_credit", 32'(credit), 32'd0);
    inp(1'b1, 5'd10, 1'b0, 2'b00, 1'b0);
    tick(); chk("t4_rej_off", 32'(coin_reject), 32'd0);
    tick(); tick(); chk("t4_credit30", 32'(credit), 32'd30);
    inp(1'b1, 5'd5, 1'b0, 2'b00, 1'b0);
    tick(); chk("t4_over_rej", 32'(coin_reject), 32'd1);
    chk("t4_over_credit", 32'(credit), 32'd30);
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b1);
    tick();
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    tick(); chk("t4_refund", 32'(balance), 32'd30);
    chk("t4_refund_bval", 32'(balance_valid), 32'd1);

    // inactivity refund after 8 CREDIT cycles
    inp(1'b1, 5'd10, 1'b0, 2'b00, 1'b0);
    tick(); chk("t5_credit10", 32'(credit), 32'd10);
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    repeat (7) tick();
    chk("t5_pre_busy", 32'(busy), 32'd0);
    chk("t5_pre_credit", 32'(credit), 32'd10);
    tick(); chk("t5_tmo_busy", 32'(busy), 32'd1);
    tick(); chk("t5_bval", 32'(balance_valid), 32'd1);
    chk("t5_balance", 32'(balance), 32'd10);

    // cancel + select + coin together
    inp(1'b1, 5'd10, 1'b0, 2'b00, 1'b0);
    tick(); chk("t5b_credit10", 32'(credit), 32'd10);
    inp(1'b1, 5'd5, 1'b1, 2'b01, 1'b1);
    tick(); chk("t5b_rej", 32'(coin_reject), 32'd1);
    chk("t5b_busy", 32'(busy), 32'd1);
    chk("t5b_short", 32'(sel_short), 32'd0);
    chk("t5b_news0", 32'(newspaper), 32'd0);
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    tick(); chk("t5b_bval", 32'(balance_valid), 32'd1);
    chk("t5b_balance", 32'(balance), 32'd10);
    chk("t5b_news1", 32'(newspaper), 32'd0);

    // reset in DISPENSE
    inp(1'b1, 5'd10, 1'b0, 2'b00, 1'b0);
    tick(); chk("t6_credit10", 32'(credit), 32'd10);
    inp(1'b0, 5'd0, 1'b1, 2'b01, 1'b0);
    tick(); chk("t6_disp_busy", 32'(busy), 32'd1);
    inp(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    dispense_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_credit", 32'(credit), 32'd0);
    chk("t6_rst_news", 32'(newspaper), 32'd0);
    tick();
    rst = 1'b0;
    tick(); chk("t6_post_news", 32'(newspaper), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd0);
    tick(); chk("t6_post_bval", 32'(balance_valid), 32'd0);
    chk("t6_post_credit", 32'(credit), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
